bram_program_loader: RTL

Parametrised loader that streams a block of words from a read-latency BRAM into a target memory, such as the RISC-V processor instruction memory. It holds the target in reset until the last word is written. It generalises the fixed 28-word, 2-cycle boot copy with these additions:
- runtime length and base address
- configurable BRAM latency
- target backpressure
- re-triggerable loads

It sits between the program BRAM and the processor write port in the pixel-clock domain.

---
 rtl/bram_program_loader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/bram_program_loader.sv
`default_nettype none
// =============================================================================
// bram_program_loader - streams a word block from a read-latency BRAM into a
// target memory, holding the target in reset until the last word lands.
// Revision: 1.0
// =============================================================================
module bram_program_loader #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 64,
    parameter int READ_LATENCY = 2,
    parameter bit AUTO_START   = 1'b1,
    parameter int DEFAULT_LEN  = 28,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [AW-1:0]         base_in,
    input  logic [AW:0]           len_in,
    output logic [AW-1:0]         bram_addr_out,
    output logic                  bram_en_out,
    input  logic [DATA_WIDTH-1:0] bram_data_in,
    output logic                  wr_valid_out,
    output logic [AW-1:0]         wr_addr_out,
    output logic [DATA_WIDTH-1:0] wr_data_out,
    input  logic                  wr_ready_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  target_rst_out,
    output logic [AW:0]           count_out
);

    localparam int BUF_DEPTH = READ_LATENCY + 2;
    localparam int PW        = $clog2(BUF_DEPTH);
    localparam int FCW       = $clog2(BUF_DEPTH + 1);
    localparam int CW        = $clog2(2 * BUF_DEPTH + 1);
    localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW:0] DEF_LEN_W = (AW+1)'(DEFAULT_LEN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic                    auto_q;
    logic [AW-1:0]           addr_q, addr_d;
    logic                    en_q, en_d;
    logic [AW:0]             len_q, len_d;
    logic [AW:0]             issued_q, issued_d;
    logic [AW:0]             count_q, count_d;
    logic                    busy_q, done_q, trst_q;
    logic [READ_LATENCY-1:0] vld_sr_q;
    logic [DATA_WIDTH-1:0]   fifo_mem_q [BUF_DEPTH];
    logic [PW-1:0]           rd_ptr_q, wr_ptr_q;
    logic [FCW-1:0]          fifo_cnt_q;

    logic                    w_push, w_pop, w_start, w_credit, w_last;
    logic [AW-1:0]           w_base;
    logic [AW:0]             w_len_raw, w_len;
    logic [CW-1:0]           w_used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push       = vld_sr_q[READ_LATENCY-1];
    assign wr_valid_out = (fifo_cnt_q != '0);
    assign wr_data_out  = fifo_mem_q[rd_ptr_q];
    assign w_pop        = wr_valid_out && wr_ready_in;
    assign w_last       = w_pop && ((count_q + 1'b1) == len_q);

    assign w_start   = ((state_q == S_IDLE) || (state_q == S_DONE)) && (start_in || auto_q);
    assign w_base    = auto_q ? '0 : base_in;
    assign w_len_raw = auto_q ? DEF_LEN_W : len_in;
    assign w_len     = (w_len_raw > DEPTH_W) ? DEPTH_W : w_len_raw;

    // Every issued read already owns a FIFO slot; the beat leaving this cycle frees one.
    always_comb begin
        w_used = CW'(fifo_cnt_q) + CW'(en_q);
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_used = w_used + CW'(vld_sr_q[i]);
        end
        w_used = w_used - CW'(w_pop);
    end
    assign w_credit = (w_used < CW'(BUF_DEPTH));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        en_d     = 1'b0;
        len_d    = len_q;
        issued_d = issued_q;
        count_d  = w_pop ? count_q + 1'b1 : count_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    len_d   = w_len;
                    count_d = '0;
                    addr_d  = w_base;
                    if (w_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_FETCH;
                        en_d     = 1'b1;
                        issued_d = (AW+1)'(1);
                    end
                end
            end
            S_FETCH: begin
                if (issued_q == len_q) begin
                    state_d = S_DRAIN;
                end else if (w_credit) begin
                    en_d     = 1'b1;
                    issued_d = issued_q + 1'b1;
                    addr_d   = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_last) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            auto_q     <= AUTO_START;
            addr_q     <= '0;
            en_q       <= 1'b0;
            len_q      <= '0;
            issued_q   <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            trst_q     <= 1'b1;
            vld_sr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            auto_q   <= 1'b0;
            addr_q   <= addr_d;
            en_q     <= en_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            count_q  <= count_d;
            busy_q   <= (state_d == S_FETCH) || (state_d == S_DRAIN);
            done_q   <= (state_d == S_DONE);
            trst_q   <= (state_d != S_DONE);
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                vld_sr_q[i] <= vld_sr_q[i-1];
            end
            vld_sr_q[0] <= en_q;
            if (w_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (w_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({w_push, w_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) fifo_mem_q[wr_ptr_q] <= bram_data_in;
    end

    assign bram_addr_out  = addr_q;
    assign bram_en_out    = en_q;
    assign wr_addr_out    = count_q[AW-1:0];
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign target_rst_out = trst_q;
    assign count_out      = count_q;

endmodule
`default_nettype wire
